// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command port between a video refill engine
//   and a cache (write-back + line fill). One 256-byte command is issued at a
//   time; the controller acknowledges it by echoing the command code.
//   Returning read data is routed to the last acknowledged owner, and video
//   words are paired into 32-bit writes to the video queue.
//
// Handshake: a command is offered by holding sys_cmd/sys_addr non-zero in
//   ISSUE until the controller drives sys_cmd_ack != 00 for at least one
//   cycle; the arbiter then drops sys_cmd and waits in ACKWAIT for
//   sys_cmd_ack to return to 00 before making the next decision.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   vid_en, vid_low          video refill enable / video queue almost empty
//   wr_req, waddr            cache write-back request and line address
//   rd_req, raddr            cache line fill request and line address
//   sys_cmd, sys_addr        registered command and word address to controller
//   sys_cmd_ack              controller acknowledge (echoes command code)
//   sys_rd_data_valid        read word valid on sys_dout
//   sys_wr_data_valid        write word consumed by controller
//   sys_dout                 read data
//   cache_wr, cache_rd       read word to cache / cache supplies write word
//   vq_data, vq_wen          paired video word and its write strobe
//   vidadr                   current video line index
//   state_dbg                FSM state (IDLE=0, ISSUE=1, ACKWAIT=2)

module sdram_arbiter #(
  parameter int VID_LAST = 2399,
  parameter int VID_BASE = 1,
  parameter int MAX_VID  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_en,
  input  logic        vid_low,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [16:0] waddr,
  input  logic [16:0] raddr,
  output logic [1:0]  sys_cmd,
  output logic [22:0] sys_addr,
  input  logic [1:0]  sys_cmd_ack,
  input  logic        sys_rd_data_valid,
  input  logic        sys_wr_data_valid,
  input  logic [15:0] sys_dout,
  output logic        cache_wr,
  output logic        cache_rd,
  output logic [31:0] vq_data,
  output logic        vq_wen,
  output logic [15:0] vidadr,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    ACKWAIT = 2'd2
  } state_t;

  localparam logic [1:0]  CMD_NOP = 2'b00;
  localparam logic [1:0]  CMD_WR  = 2'b01;
  localparam logic [1:0]  CMD_VID = 2'b10;
  localparam logic [1:0]  CMD_RD  = 2'b11;
  localparam logic [2:0]  MAX_VID_C  = 3'(MAX_VID);
  localparam logic [15:0] VID_LAST_C = 16'(VID_LAST);
  localparam logic        VID_BASE_C = 1'(VID_BASE);

  state_t      state, next_state;
  logic [1:0]  grant_cmd;
  logic [22:0] grant_addr;
  logic        vid_win;
  logic        issue_ack;
  logic [2:0]  vid_cnt;
  logic        owner;
  logic        phase;

  assign state_dbg = state;

  // Video wins unless it has used up its run of grants while the cache waits.
  assign vid_win   = vid_en && vid_low && !((vid_cnt == MAX_VID_C) && (wr_req || rd_req));
  assign issue_ack = (state == ISSUE) && (sys_cmd_ack != CMD_NOP);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_cmd  = CMD_NOP;
    grant_addr = '0;
    case (state)
      IDLE: begin
        if (vid_win) begin
          grant_cmd  = CMD_VID;
          grant_addr = {VID_BASE_C, vidadr, 6'b0};
        end else if (wr_req) begin
          grant_cmd  = CMD_WR;
          grant_addr = {waddr, 6'b0};
        end else if (rd_req) begin
          grant_cmd  = CMD_RD;
          grant_addr = {raddr, 6'b0};
        end
        if (grant_cmd != CMD_NOP) next_state = ISSUE;
      end
      ISSUE: begin
        if (sys_cmd_ack != CMD_NOP) next_state = ACKWAIT;
      end
      ACKWAIT: begin
        if (sys_cmd_ack == CMD_NOP) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ------------------------------------------------- command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_cmd  <= CMD_NOP;
      sys_addr <= '0;
    end else if (grant_cmd != CMD_NOP) begin
      sys_cmd  <= grant_cmd;
      sys_addr <= grant_addr;
    end else if (issue_ack) begin
      sys_cmd  <= CMD_NOP;
    end
  end

  // Video run-length counter used for fairness against the cache.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vid_cnt <= '0;
    end else if (grant_cmd == CMD_VID) begin
      if (vid_cnt != MAX_VID_C) vid_cnt <= vid_cnt + 3'd1;
    end else if (grant_cmd != CMD_NOP) begin
      vid_cnt <= '0;
    end
  end

  // ------------------------------------- ownership, video line, pairing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= 1'b0;
      vidadr  <= '0;
      phase   <= 1'b0;
      vq_data <= '0;
      vq_wen  <= 1'b0;
    end else begin
      vq_wen <= 1'b0;
      if (!owner && sys_rd_data_valid) begin
        if (!phase) begin
          vq_data[15:0] <= sys_dout;
        end else begin
          vq_data[31:16] <= sys_dout;
          vq_wen         <= 1'b1;
        end
        phase <= ~phase;
      end
      // Ownership only changes on an acknowledge, so read data trailing the
      // ack still reaches the previous owner until the next command is acked.
      if (issue_ack) begin
        owner <= (sys_cmd != CMD_VID);
        if (sys_cmd == CMD_VID) begin
          vidadr <= (vidadr == VID_LAST_C) ? 16'd0 : vidadr + 16'd1;
          phase  <= 1'b0;  // each line starts on a fresh word pair
        end
      end
    end
  end

  assign cache_wr = owner && sys_rd_data_valid;
  assign cache_rd = owner && sys_wr_data_valid;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter: reset values, video-only issue,
// line-index wrap, video word pairing, video/cache fairness, write-back
// priority with stray-ack immunity, and reset in the middle of a command.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vid_en = 1'b0, vid_low = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [16:0] waddr = '0, raddr = '0;
  logic [1:0]  sys_cmd;
  logic [22:0] sys_addr;
  logic [1:0]  sys_cmd_ack = '0;
  logic        sys_rd_data_valid = 1'b0, sys_wr_data_valid = 1'b0;
  logic [15:0] sys_dout = '0;
  logic        cache_wr, cache_rd, vq_wen;
  logic [31:0] vq_data;
  logic [15:0] vidadr;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int failed    = 0;

  // ---------------------------------------------- clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sdram_arbiter dut (
    .clk(clk), .rst(rst), .vid_en(vid_en), .vid_low(vid_low),
    .wr_req(wr_req), .rd_req(rd_req), .waddr(waddr), .raddr(raddr),
    .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
    .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
    .sys_dout(sys_dout), .cache_wr(cache_wr), .cache_rd(cache_rd),
    .vq_data(vq_data), .vq_wen(vq_wen), .vidadr(vidadr), .state_dbg(state_dbg)
  );

  // ----------------------------------------------------- driver tasks
  task automatic drive_idle_inputs();
    vid_en = 1'b0; vid_low = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    waddr = '0; raddr = '0; sys_cmd_ack = 2'b00;
    sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0; sys_dout = '0;
  endtask

  task automatic apply_reset();
    drive_idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) at negedges until a command is presented.
  task automatic wait_cmd();
    for (int i = 0; i < 20; i++) begin
      if (sys_cmd !== 2'b00) break;
      @(negedge clk);
    end
  endtask

  // One-cycle acknowledge followed by a return to 00.
  task automatic do_ack(input logic [1:0] code);
    sys_cmd_ack = code;
    @(negedge clk);
    sys_cmd_ack = 2'b00;
    @(negedge clk);
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    drive_idle_inputs();
    vid_en = 1'b1; vid_low = 1'b1; rd_req = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b00 || sys_addr !== 23'h0) begin
      failed++;
      $display("FAIL reset_cmd: got cmd=%b addr=%h, need 00 / 000000", sys_cmd, sys_addr);
    end
    tests_run++;
    if (state_dbg !== 2'd0 || vidadr !== 16'd0) begin
      failed++;
      $display("FAIL reset_state: got state=%0d vidadr=%0d, need 0 / 0", state_dbg, vidadr);
    end
    tests_run++;
    if (vq_wen !== 1'b0 || vq_data !== 32'h0) begin
      failed++;
      $display("FAIL reset_vq: got wen=%b data=%h, need 0 / 00000000", vq_wen, vq_data);
    end
    // owner resets to video, so read data must not go to the cache
    sys_rd_data_valid = 1'b1;
    #1;
    tests_run++;
    if (cache_wr !== 1'b0) begin
      failed++;
      $display("FAIL reset_owner: got cache_wr=%b, need 0", cache_wr);
    end
    sys_rd_data_valid = 1'b0;
    drive_idle_inputs();
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_video_only();
    apply_reset();
    vid_en = 1'b1; vid_low = 1'b1;
    wait_cmd();
    tests_run++;
    if (sys_cmd !== 2'b10 || sys_addr !== 23'h400000) begin
      failed++;
      $display("FAIL vid_issue: got cmd=%b addr=%h, need 10 / 400000", sys_cmd, sys_addr);
    end
    vid_low = 1'b0;  // request dropped during ISSUE: command must still complete
    repeat (3) @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b10 || state_dbg !== 2'd1 || vidadr !== 16'd0) begin
      failed++;
      $display("FAIL vid_hold: got cmd=%b state=%0d vidadr=%0d, need 10 / 1 / 0",
               sys_cmd, state_dbg, vidadr);
    end
    sys_cmd_ack = 2'b10;
    @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b00 || state_dbg !== 2'd2 || vidadr !== 16'd1) begin
      failed++;
      $display("FAIL vid_ack: got cmd=%b state=%0d vidadr=%0d, need 00 / 2 / 1",
               sys_cmd, state_dbg, vidadr);
    end
    @(negedge clk);
    sys_cmd_ack = 2'b00;
    @(negedge clk);
    tests_run++;
    if (state_dbg !== 2'd0 || sys_cmd !== 2'b00) begin
      failed++;
      $display("FAIL vid_idle: got state=%0d cmd=%b, need 0 / 00", state_dbg, sys_cmd);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    vid_en = 1'b1; vid_low = 1'b1;
    for (int n = 0; n < 2399; n++) begin
      wait_cmd();
      do_ack(2'b10);
    end
    wait_cmd();
    tests_run++;
    if (vidadr !== 16'd2399 || sys_addr !== 23'h4257C0) begin
      failed++;
      $display("FAIL wrap_last: got vidadr=%0d addr=%h, need 2399 / 4257c0", vidadr, sys_addr);
    end
    vid_low = 1'b0;
    do_ack(2'b10);
    tests_run++;
    if (vidadr !== 16'd0) begin
      failed++;
      $display("FAIL wrap_zero: got vidadr=%0d, need 0", vidadr);
    end
  endtask

  task automatic test_pairing();
    int          pulses;
    int          bad_cache;
    logic [31:0] first_d, last_d;
    apply_reset();
    pulses = 0; bad_cache = 0; first_d = '0; last_d = '0;
    for (int i = 1; i <= 128; i++) begin
      sys_rd_data_valid = 1'b1;
      sys_dout = 16'(i);
      #1;
      if (cache_wr !== 1'b0) bad_cache++;
      @(negedge clk);
      if (vq_wen === 1'b1) begin
        pulses++;
        if (pulses == 1) first_d = vq_data;
        last_d = vq_data;
      end
    end
    sys_rd_data_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pulses != 64 || vq_wen !== 1'b0) begin
      failed++;
      $display("FAIL pair_count: got %0d pulses (wen after=%b), need 64 / 0", pulses, vq_wen);
    end
    tests_run++;
    if (first_d !== 32'h00020001 || last_d !== 32'h0080007F) begin
      failed++;
      $display("FAIL pair_data: got first=%h last=%h, need 00020001 / 0080007f", first_d, last_d);
    end
    tests_run++;
    if (bad_cache != 0) begin
      failed++;
      $display("FAIL pair_cache: got %0d cycles with cache_wr=1, need 0", bad_cache);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [6];
    int         bad_route;
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    apply_reset();
    vid_en = 1'b1; vid_low = 1'b1; rd_req = 1'b1; raddr = 17'h00155;
    bad_route = 0;
    for (int k = 0; k < 6; k++) begin
      wait_cmd();
      tests_run++;
      if (sys_cmd !== exp_seq[k]) begin
        failed++;
        $display("FAIL fair_grant%0d: got cmd=%b, need %b", k, sys_cmd, exp_seq[k]);
      end
      if (k == 4) begin
        tests_run++;
        if (sys_addr !== 23'h005540) begin
          failed++;
          $display("FAIL fair_raddr: got addr=%h, need 005540", sys_addr);
        end
        rd_req = 1'b0;
      end
      do_ack(exp_seq[k]);
      if (k == 4) begin
        for (int w = 0; w < 4; w++) begin
          sys_rd_data_valid = 1'b1;
          sys_dout = 16'hA000 + 16'(w);
          #1;
          if (cache_wr !== 1'b1 || vq_wen !== 1'b0) bad_route++;
          @(negedge clk);
        end
        sys_rd_data_valid = 1'b0;
        tests_run++;
        if (bad_route != 0) begin
          failed++;
          $display("FAIL fair_route: got %0d misrouted words, need 0", bad_route);
        end
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    vid_en = 1'b0; vid_low = 1'b1;
    wr_req = 1'b1; rd_req = 1'b1;
    waddr = 17'h00012; raddr = 17'h00034;
    wait_cmd();
    tests_run++;
    if (sys_cmd !== 2'b01 || sys_addr !== 23'h000480) begin
      failed++;
      $display("FAIL prio_write: got cmd=%b addr=%h, need 01 / 000480", sys_cmd, sys_addr);
    end
    wr_req = 1'b0;
    do_ack(2'b01);
    sys_wr_data_valid = 1'b1;
    #1;
    tests_run++;
    if (cache_rd !== 1'b1 || cache_wr !== 1'b0) begin
      failed++;
      $display("FAIL prio_cache_rd: got cache_rd=%b cache_wr=%b, need 1 / 0", cache_rd, cache_wr);
    end
    @(negedge clk);
    sys_wr_data_valid = 1'b0;
    #1;
    tests_run++;
    if (cache_rd !== 1'b0) begin
      failed++;
      $display("FAIL prio_cache_rd_off: got cache_rd=%b, need 0", cache_rd);
    end
    wait_cmd();
    tests_run++;
    if (sys_cmd !== 2'b11 || sys_addr !== 23'h000D00) begin
      failed++;
      $display("FAIL prio_read: got cmd=%b addr=%h, need 11 / 000d00", sys_cmd, sys_addr);
    end
    rd_req = 1'b0;
    do_ack(2'b11);
    // stray video ack while idle must not move ownership or the line index
    sys_cmd_ack = 2'b10;
    @(negedge clk);
    sys_cmd_ack = 2'b00;
    @(negedge clk);
    sys_rd_data_valid = 1'b1;
    #1;
    tests_run++;
    if (cache_wr !== 1'b1 || vidadr !== 16'd0 || state_dbg !== 2'd0 || sys_cmd !== 2'b00) begin
      failed++;
      $display("FAIL prio_stray_ack: got cache_wr=%b vidadr=%0d state=%0d cmd=%b, need 1 / 0 / 0 / 00",
               cache_wr, vidadr, state_dbg, sys_cmd);
    end
    sys_rd_data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    vid_en = 1'b1; vid_low = 1'b1;
    wait_cmd();
    do_ack(2'b10);
    vid_en = 1'b0; rd_req = 1'b1; raddr = 17'h00007;
    wait_cmd();
    tests_run++;
    if (sys_cmd !== 2'b11 || state_dbg !== 2'd1 || vidadr !== 16'd1) begin
      failed++;
      $display("FAIL rmid_issue: got cmd=%b state=%0d vidadr=%0d, need 11 / 1 / 1",
               sys_cmd, state_dbg, vidadr);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (sys_cmd !== 2'b00 || state_dbg !== 2'd0 || vidadr !== 16'd0) begin
      failed++;
      $display("FAIL rmid_async: got cmd=%b state=%0d vidadr=%0d, need 00 / 0 / 0",
               sys_cmd, state_dbg, vidadr);
    end
    vid_en = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (sys_cmd !== 2'b00) begin
      failed++;
      $display("FAIL rmid_held: got cmd=%b during reset, need 00", sys_cmd);
    end
    rd_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    wait_cmd();
    tests_run++;
    if (sys_cmd !== 2'b10 || sys_addr !== 23'h400000) begin
      failed++;
      $display("FAIL rmid_restart: got cmd=%b addr=%h, need 10 / 400000", sys_cmd, sys_addr);
    end
  endtask

  // --------------------------------------------------- sequence/report
  initial begin
    test_reset();
    test_video_only();
    test_wrap();
    test_pairing();
    test_fairness();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter VID_LAST, default 2399: last video line index (640x480x2 bytes / 256 - 1); the counter wraps after it.
REQ-002 Parameter VID_BASE, default 1: sys_addr[22] for video reads, selecting the framebuffer half.
REQ-003 Parameter MAX_VID, default 4: maximum consecutive video grants while a cache request waits.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock (SDRAM clock domain).
- rst  in  1  asynchronous, active-low reset.
- vid_en  in  1  video refill enabled.
- vid_low  in  1  video queue almost empty.
- wr_req  in  1  cache write-back request (level).
- rd_req  in  1  cache line fill request (level).
- waddr  in  17  write-back line address.
- raddr  in  17  fill line address.
- sys_cmd  out  2  00 nop, 01 write 256 B, 10 video read 256 B, 11 cache read 256 B.
- sys_addr  out  23  SDRAM word address.
- sys_cmd_ack  in  2  controller acknowledge, echoing the accepted command code.
- sys_rd_data_valid  in  1  read data word valid.
- sys_wr_data_valid  in  1  write data word consumed.
- sys_dout  in  16  read data from the controller.
- cache_wr  out  1  read word goes to the cache.
- cache_rd  out  1  cache supplies the write word.
- vq_data  out  32  video queue write data.
- vq_wen  out  1  video queue write strobe.
- vidadr  out  16  current video line index.

Function
REQ-005 The FSM SHALL have three states.
- IDLE: select a requester and go to ISSUE.
- ISSUE: hold sys_cmd and sys_addr until sys_cmd_ack != 00.
- ACKWAIT: wait for sys_cmd_ack == 00, then return to IDLE.
REQ-006 In IDLE, vid_en && vid_low SHALL win, unless vid_cnt == MAX_VID and (wr_req || rd_req).
REQ-007 Among cache requests, wr_req SHALL take priority over rd_req so a write-back precedes its line fill.
REQ-008 vid_cnt (3 bits) SHALL increment on each video grant, saturating at MAX_VID, and SHALL clear on any cache grant.
REQ-009 sys_cmd and sys_addr SHALL be registered; they are valid from the cycle after the IDLE decision.
REQ-010 sys_addr SHALL be formed as follows.
- Write: {waddr, 6'b0}.
- Cache read: {raddr, 6'b0}.
- Video: {VID_BASE, vidadr, 6'b0}.
REQ-011 On the first ISSUE cycle with sys_cmd_ack != 00, sys_cmd SHALL go to 00 on the next cycle.
REQ-012 On that same ack cycle, the owner flag SHALL latch: 1 for cache commands, 0 for video.
REQ-013 The owner flag SHALL hold until the next acknowledge; data that trails the ack (after ACKWAIT) SHALL still route to the owner.
REQ-014 On a video acknowledge, vidadr SHALL increment, wrapping from VID_LAST to 0.
REQ-015 Outside ISSUE, an ack value that differs from the issued command SHALL be ignored.
REQ-016 cache_wr SHALL equal owner && sys_rd_data_valid, combinationally.
REQ-017 cache_rd SHALL equal owner && sys_wr_data_valid, combinationally.
REQ-018 Video pairing: with owner=0 and sys_rd_data_valid, on phase 0 latch sys_dout into vq_data[15:0] and toggle phase.
REQ-019 On phase 1, latch sys_dout into vq_data[31:16], pulse vq_wen for exactly 1 cycle, and toggle phase.
REQ-020 The pairing phase SHALL clear on every video acknowledge, so each line yields exactly 64 vq_wen pulses for 128 words.
REQ-021 If a request drops while in ISSUE, the command SHALL still complete; no abort.
REQ-022 If vid_en is 0, video SHALL never be granted and vidadr SHALL hold.
REQ-023 Simultaneous video, write and read requests with vid_cnt < MAX_VID SHALL grant video.

Reset
REQ-024 While rst=0, asynchronously:
- state=IDLE, sys_cmd=00, sys_addr=0.
- owner=0, vid_cnt=0, vidadr=0, phase=0.
- vq_data=0, vq_wen=0.
REQ-025 Reset asserted mid-command or mid-burst SHALL abandon it; after release, the first grant restarts from vidadr=0.

Verification
REQ-026 Video only: vid_en=1, vid_low=1, ack 10 for 2 cycles after 3 -> sys_cmd=10, sys_addr=0x400000, vidadr 0->1, then back to IDLE.
REQ-027 Wrap: vidadr=2399, video ack -> vidadr=0.
REQ-028 Pairing: owner=0, 128 valid words 0x0001..0x0080 -> 64 vq_wen pulses; first vq_data=0x00020001, last 0x0080007F.
REQ-029 Fairness: vid_low and rd_req held high -> grants V,V,V,V,R,V,...; after the read ack, the next 4 rd words assert cache_wr.
REQ-030 Priority: wr_req and rd_req together, waddr=0x00012 -> sys_cmd=01, sys_addr=0x000480; cache_rd follows sys_wr_data_valid.
REQ-031 Reset: rst=0 during ISSUE with sys_cmd=11 -> sys_cmd=00 immediately; no grant until rst=1.
